id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register for the MIPS150. Sits directly upstream of the ALU and drives its A, B and ALUop from registers.
- Resolves register operands by forwarding from the EX, MEM and WB stages, and selects immediate or shamt sources.
- Detects load-use hazards and stalls decode, handles branch flush and back-end hold, and counts stall cycles.

---
 rtl/id_ex_operand_stage_pkg.sv | 32 +++
 rtl/id_ex_operand_stage_fwd_mux.sv | 31 +++
 rtl/id_ex_operand_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the MIPS150 ID/EX stage: ALU operation codes and
// operand-source selector encodings.
package id_ex_operand_stage_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_XXX  = 4'd15;

  localparam logic ASEL_RS = 1'b0;
  localparam logic ASEL_RT = 1'b1;

  typedef enum logic [1:0] {
    BSEL_RT    = 2'd0,
    BSEL_IMM   = 2'd1,
    BSEL_SHAMT = 2'd2,
    BSEL_RSVD  = 2'd3
  } bsel_e;

  // A bubble is an ADDU of zeros with no write-back: harmless if it leaks.
  localparam logic [3:0] ALUOP_BUBBLE = ALU_ADDU;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding mux: resolves one source register against the EX, MEM
// and WB producers (youngest first), falling back to register-file data.
module id_ex_operand_stage_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_we_i,
  input  logic [REG_W-1:0]  ex_dest_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              mem_we_i,
  input  logic [REG_W-1:0]  mem_dest_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_we_i,
  input  logic [REG_W-1:0]  wb_dest_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] fwd_o
);

  always_comb begin
    if (src_i == '0)                               fwd_o = '0;
    else if (ex_we_i  && (ex_dest_i  == src_i))    fwd_o = ex_result_i;
    else if (mem_we_i && (mem_dest_i == src_i))    fwd_o = mem_result_i;
    else if (wb_we_i  && (wb_dest_i  == src_i))    fwd_o = wb_result_i;
    else                                           fwd_o = rf_data_i;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// MIPS150 ID/EX pipeline register: forwards operands into registered ALU
// inputs, detects load-use hazards, handles flush/hold and counts stalls.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_asel,
  input  logic [1:0]        id_bsel,
  input  logic [3:0]        id_aluop,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_dest,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [3:0]        ex_aluop,
  output logic [REG_W-1:0]  ex_dest,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [3:0]        ex_aluop_q, ex_aluop_d;
  logic [REG_W-1:0]  ex_dest_q, ex_dest_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              ex_fwd_en;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  logic [DATA_W-1:0] operand_b;
  logic              load_use;
  logic              bubble;

  // A load in EX has no result yet, so it must not forward; bubbles never forward.
  assign ex_fwd_en = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src_i        (id_rs),
    .rf_data_i    (id_rs_data),
    .ex_we_i      (ex_fwd_en),
    .ex_dest_i    (ex_dest_q),
    .ex_result_i  (ex_result),
    .mem_we_i     (mem_reg_write),
    .mem_dest_i   (mem_dest),
    .mem_result_i (mem_result),
    .wb_we_i      (wb_reg_write),
    .wb_dest_i    (wb_dest),
    .wb_result_i  (wb_result),
    .fwd_o        (fwd_rs)
  );

  id_ex_operand_stage_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src_i        (id_rt),
    .rf_data_i    (id_rt_data),
    .ex_we_i      (ex_fwd_en),
    .ex_dest_i    (ex_dest_q),
    .ex_result_i  (ex_result),
    .mem_we_i     (mem_reg_write),
    .mem_dest_i   (mem_dest),
    .mem_result_i (mem_result),
    .wb_we_i      (wb_reg_write),
    .wb_dest_i    (wb_dest),
    .wb_result_i  (wb_result),
    .fwd_o        (fwd_rt)
  );

  // Hazard is raised on index match alone, even if the operand is unused.
  assign load_use = id_valid & ex_valid_q & ex_mem_read_q & (ex_dest_q != '0) &
                    ((ex_dest_q == id_rs) | (ex_dest_q == id_rt));
  assign stall_id = hold | (load_use & ~flush);
  assign bubble   = flush | load_use | ~id_valid;

  always_comb begin
    case (bsel_e'(id_bsel))
      BSEL_RT:    operand_b = fwd_rt;
      BSEL_IMM:   operand_b = id_imm;
      BSEL_SHAMT: operand_b = {{(DATA_W-5){1'b0}}, id_shamt};
      default:    operand_b = '0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no
    // path through the if/else tree can leave one unassigned and infer a latch.
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_a_d         = ex_a_q;
    ex_b_d         = ex_b_q;
    ex_aluop_d     = ex_aluop_q;
    ex_dest_d      = ex_dest_q;
    ex_rt_data_d   = ex_rt_data_q;
    stall_cnt_d    = stall_cnt_q;

    if (!hold) begin
      if (bubble) begin
        ex_valid_d     = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_a_d         = '0;
        ex_b_d         = '0;
        ex_aluop_d     = ALUOP_BUBBLE;
      end else begin
        ex_valid_d     = 1'b1;
        ex_reg_write_d = id_reg_write;
        ex_mem_read_d  = id_mem_read;
        ex_a_d         = (id_asel == ASEL_RT) ? fwd_rt : fwd_rs;
        ex_b_d         = operand_b;
        ex_aluop_d     = id_aluop;
        ex_dest_d      = id_dest;
        ex_rt_data_d   = fwd_rt;
      end

      if (load_use && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_a_q         <= '0;
      ex_b_q         <= '0;
      ex_aluop_q     <= ALU_ADDU;
      ex_dest_q      <= '0;
      ex_rt_data_q   <= '0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_a_q         <= ex_a_d;
      ex_b_q         <= ex_b_d;
      ex_aluop_q     <= ex_aluop_d;
      ex_dest_q      <= ex_dest_d;
      ex_rt_data_q   <= ex_rt_data_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign ex_aluop     = ex_aluop_q;
  assign ex_dest      = ex_dest_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic against a behavioural pipeline model.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_asel, id_reg_write, id_mem_read;
  logic [4:0]  id_rs, id_rt, id_dest, id_shamt, mem_dest, wb_dest;
  logic [31:0] id_rs_data, id_rt_data, id_imm, ex_result, mem_result, wb_result;
  logic [1:0]  id_bsel;
  logic [3:0]  id_aluop;
  logic        mem_reg_write, wb_reg_write, flush, hold;

  logic        ex_valid, ex_reg_write, ex_mem_read, stall_id;
  logic [31:0] ex_a, ex_b, ex_rt_data;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_dest;
  logic [15:0] stall_cnt;

  // Narrow-counter instance sharing all inputs, used to reach saturation quickly.
  logic        s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_stall_id;
  logic [31:0] s_ex_a, s_ex_b, s_ex_rt_data;
  logic [3:0]  s_ex_aluop;
  logic [4:0]  s_ex_dest;
  logic [3:0]  s_stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_asel(id_asel), .id_bsel(id_bsel), .id_aluop(id_aluop),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_result(ex_result), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
    .wb_result(wb_result), .flush(flush), .hold(hold), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_a(ex_a), .ex_b(ex_b),
    .ex_aluop(ex_aluop), .ex_dest(ex_dest), .ex_rt_data(ex_rt_data),
    .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  id_ex_operand_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_asel(id_asel), .id_bsel(id_bsel), .id_aluop(id_aluop),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_result(ex_result), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
    .wb_result(wb_result), .flush(flush), .hold(hold), .ex_valid(s_ex_valid),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read), .ex_a(s_ex_a),
    .ex_b(s_ex_b), .ex_aluop(s_ex_aluop), .ex_dest(s_ex_dest),
    .ex_rt_data(s_ex_rt_data), .stall_id(s_stall_id), .stall_cnt(s_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_data = '0; id_rt_data = '0;
    id_imm = '0; id_shamt = '0; id_asel = ASEL_RS; id_bsel = BSEL_RT;
    id_aluop = ALU_ADDU; id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    ex_result = '0; mem_reg_write = 1'b0; mem_dest = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_dest = '0; wb_result = '0; flush = 1'b0; hold = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic asel, input logic [1:0] bsel, input logic [3:0] op,
                        input logic [4:0] dest, input logic rw, input logic mr);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rs_data = rs_d; id_rt_data = rt_d;
    id_asel = asel; id_bsel = bsel; id_aluop = op; id_dest = dest;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    total_cnt++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid); else pass_cnt++;
    total_cnt++; if (ex_aluop !== ALU_ADDU) $display("FAIL reset_aluop: got %h want %h", ex_aluop, ALU_ADDU); else pass_cnt++;
    total_cnt++; if ({ex_a, ex_b, ex_rt_data} !== 96'h0) $display("FAIL reset_operands: got %h %h %h want 0", ex_a, ex_b, ex_rt_data); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", stall_cnt); else pass_cnt++;
    rst = 1'b0;
    set_id(5'd1, 5'd2, 32'h11, 32'h22, ASEL_RS, BSEL_RT, ALU_SUBU, 5'd3, 1'b1, 1'b0);
    tick();
    total_cnt++; if (ex_valid !== 1'b1 || ex_a !== 32'h11) $display("FAIL pre_reset_capture: got valid=%b a=%h want 1/11", ex_valid, ex_a); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000) $display("FAIL async_reset_ctrl: got %b want 000", {ex_valid, ex_reg_write, ex_mem_read}); else pass_cnt++;
    total_cnt++; if ({ex_a, ex_b, ex_rt_data, 27'(ex_dest)} !== '0) $display("FAIL async_reset_data: got a=%h b=%h rt=%h dest=%h want 0", ex_a, ex_b, ex_rt_data, ex_dest); else pass_cnt++;
    total_cnt++; if (ex_aluop !== ALU_ADDU) $display("FAIL async_reset_aluop: got %h want %h", ex_aluop, ALU_ADDU); else pass_cnt++;
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd0, 5'd0, 32'h0, 32'h0, ASEL_RS, BSEL_IMM, ALU_ADDU, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(5'd4, 5'd0, 32'h4444, 32'h0, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL mid_stall_pre: got %b want 1", stall_id); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (stall_id !== 1'b0 || stall_cnt !== 16'h0) $display("FAIL mid_stall_reset: got stall=%b cnt=%h want 0/0", stall_id, stall_cnt); else pass_cnt++;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL post_reset_stall: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (ex_valid !== 1'b1 || ex_a !== 32'h4444) $display("FAIL post_reset_issue: got valid=%b a=%h want 1/4444", ex_valid, ex_a); else pass_cnt++;
    clear_inputs();
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    set_id(5'd1, 5'd2, 32'd5, 32'd7, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd3, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL basic_stall: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (ex_a !== 32'd5 || ex_b !== 32'd7) $display("FAIL basic_ab: got a=%h b=%h want 5/7", ex_a, ex_b); else pass_cnt++;
    total_cnt++; if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b110) $display("FAIL basic_ctrl: got %b want 110", {ex_valid, ex_reg_write, ex_mem_read}); else pass_cnt++;
    total_cnt++; if (ex_dest !== 5'd3 || ex_aluop !== ALU_ADDU || ex_rt_data !== 32'd7) $display("FAIL basic_fields: got dest=%h op=%h rt=%h want 3/0/7", ex_dest, ex_aluop, ex_rt_data); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_forward_priority();
    set_id(5'd0, 5'd0, 32'h0, 32'h0, ASEL_RS, BSEL_IMM, ALU_ADDU, 5'd1, 1'b1, 1'b0);
    tick();
    set_id(5'd1, 5'd2, 32'h99, 32'h77, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd7, 1'b1, 1'b0);
    ex_result = 32'h10;
    mem_reg_write = 1'b1; mem_dest = 5'd1; mem_result = 32'h20;
    wb_reg_write = 1'b1; wb_dest = 5'd1; wb_result = 32'h30;
    tick();
    total_cnt++; if (ex_a !== 32'h10) $display("FAIL fwd_ex_priority: got %h want 10", ex_a); else pass_cnt++;
    total_cnt++; if (ex_b !== 32'h77) $display("FAIL fwd_rf_fallback: got %h want 77", ex_b); else pass_cnt++;
    set_id(5'd0, 5'd2, 32'h55, 32'h77, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd7, 1'b1, 1'b0);
    mem_dest = 5'd0; wb_dest = 5'd0;
    tick();
    total_cnt++; if (ex_a !== 32'h0) $display("FAIL fwd_zero_reg: got %h want 0", ex_a); else pass_cnt++;
    set_id(5'd1, 5'd1, 32'h99, 32'h88, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd7, 1'b1, 1'b0);
    mem_dest = 5'd1; wb_dest = 5'd1;
    tick();
    total_cnt++; if (ex_a !== 32'h20 || ex_b !== 32'h20) $display("FAIL fwd_mem_over_wb: got a=%h b=%h want 20/20", ex_a, ex_b); else pass_cnt++;
    mem_reg_write = 1'b0;
    tick();
    total_cnt++; if (ex_a !== 32'h30 || ex_rt_data !== 32'h30) $display("FAIL fwd_wb: got a=%h rt=%h want 30/30", ex_a, ex_rt_data); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_load_use();
    set_id(5'd0, 5'd0, 32'h0, 32'h0, ASEL_RS, BSEL_IMM, ALU_ADDU, 5'd4, 1'b1, 1'b1);
    tick();
    set_id(5'd4, 5'd0, 32'h1234, 32'h0, ASEL_RS, BSEL_RT, ALU_OR, 5'd8, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall_id !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_id); else pass_cnt++;
    tick();
    exp_cnt++;
    total_cnt++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_a !== 32'h0 || ex_b !== 32'h0 || ex_aluop !== ALU_ADDU) $display("FAIL lu_bubble: got v=%b rw=%b a=%h b=%h op=%h want 0/0/0/0/0", ex_valid, ex_reg_write, ex_a, ex_b, ex_aluop); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'(exp_cnt)) $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); else pass_cnt++;
    mem_reg_write = 1'b1; mem_dest = 5'd4; mem_result = 32'hABCD;
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL lu_release: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (ex_valid !== 1'b1 || ex_a !== 32'hABCD || ex_aluop !== ALU_OR) $display("FAIL lu_mem_fwd: got v=%b a=%h op=%h want 1/abcd/5", ex_valid, ex_a, ex_aluop); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_shift();
    set_id(5'd0, 5'd6, 32'h0, 32'h1, ASEL_RT, BSEL_SHAMT, ALU_SLL, 5'd5, 1'b1, 1'b0);
    id_shamt = 5'd3;
    tick();
    total_cnt++; if (ex_a !== 32'h1 || ex_b !== 32'h3) $display("FAIL shift_ab: got a=%h b=%h want 1/3", ex_a, ex_b); else pass_cnt++;
    id_bsel = BSEL_RSVD;
    tick();
    total_cnt++; if (ex_b !== 32'h0) $display("FAIL bsel_reserved: got %h want 0", ex_b); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_flush_load_use();
    set_id(5'd0, 5'd0, 32'h0, 32'h0, ASEL_RS, BSEL_IMM, ALU_ADDU, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd9, 32'h0, 32'h9, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd2, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    total_cnt++; if (stall_id !== 1'b0) $display("FAIL flush_lu_stall: got %b want 0", stall_id); else pass_cnt++;
    tick();
    total_cnt++; if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_cnt)) $display("FAIL flush_lu_bubble: got v=%b cnt=%0d want 0/%0d", ex_valid, stall_cnt, exp_cnt); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_hold();
    set_id(5'd1, 5'd2, 32'h111, 32'h222, ASEL_RS, BSEL_RT, ALU_OR, 5'd10, 1'b1, 1'b0);
    tick();
    set_id(5'd10, 5'd3, 32'hDEAD, 32'hBEEF, ASEL_RT, BSEL_IMM, ALU_XOR, 5'd11, 1'b0, 1'b1);
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (stall_id !== 1'b1) $display("FAIL hold_stall_%0d: got %b want 1", i, stall_id); else pass_cnt++;
      tick();
      total_cnt++; if (ex_valid !== 1'b1 || ex_a !== 32'h111 || ex_b !== 32'h222 || ex_aluop !== ALU_OR || ex_dest !== 5'd10) $display("FAIL hold_frozen_%0d: got v=%b a=%h b=%h op=%h d=%h want 1/111/222/5/a", i, ex_valid, ex_a, ex_b, ex_aluop, ex_dest); else pass_cnt++;
      total_cnt++; if (stall_cnt !== 16'(exp_cnt)) $display("FAIL hold_cnt_%0d: got %0d want %0d", i, stall_cnt, exp_cnt); else pass_cnt++;
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      set_id(5'd0, 5'd0, 32'h0, 32'h0, ASEL_RS, BSEL_IMM, ALU_ADDU, 5'd4, 1'b1, 1'b1);
      tick();
      set_id(5'd4, 5'd4, 32'h0, 32'h0, ASEL_RS, BSEL_RT, ALU_ADDU, 5'd0, 1'b0, 1'b0);
      tick();
      total_cnt++; if (s_stall_cnt !== 4'((k > 15) ? 15 : k)) $display("FAIL sat_cnt_%0d: got %0d want %0d", k, s_stall_cnt, (k > 15) ? 15 : k); else pass_cnt++;
      total_cnt++; if (stall_cnt !== 16'(k)) $display("FAIL wide_cnt_%0d: got %0d want %0d", k, stall_cnt, k); else pass_cnt++;
    end
    clear_inputs();
  endtask

  // Behavioural model of the EX-stage contents, stepped once per clock edge.
  typedef struct {
    logic valid, rw, mr;
    logic [31:0] a, b, rtd;
    logic [3:0] op;
    logic [4:0] dest;
    int cnt;
  } ex_model_t;

  function automatic logic [31:0] model_fwd(ex_model_t m, logic [4:0] s, logic [31:0] rf);
    logic        en [3];
    logic [4:0]  dst [3];
    logic [31:0] val [3];
    if (s == 0) return 32'h0;
    en[0] = m.valid && m.rw && !m.mr; dst[0] = m.dest;  val[0] = ex_result;
    en[1] = mem_reg_write;            dst[1] = mem_dest; val[1] = mem_result;
    en[2] = wb_reg_write;             dst[2] = wb_dest;  val[2] = wb_result;
    for (int i = 0; i < 3; i++) if (en[i] && dst[i] == s) return val[i];
    return rf;
  endfunction

  task automatic test_random();
    ex_model_t m;
    logic lu, exp_stall;
    logic [31:0] fr, ft;
    clear_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    m = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, a: 32'h0, b: 32'h0, rtd: 32'h0, op: ALU_ADDU, dest: 5'd0, cnt: 0};
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(7) != 0);
      id_rs = 5'($urandom_range(7)); id_rt = 5'($urandom_range(7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_asel = 1'($urandom); id_bsel = 2'($urandom);
      id_aluop = 4'($urandom); id_dest = 5'($urandom_range(7));
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(2) == 0);
      ex_result = $urandom;
      mem_reg_write = 1'($urandom); mem_dest = 5'($urandom_range(7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom); wb_dest = 5'($urandom_range(7)); wb_result = $urandom;
      flush = ($urandom_range(7) == 0); hold = ($urandom_range(7) == 0);

      lu = id_valid && m.valid && m.mr && m.dest != 0 && (m.dest == id_rs || m.dest == id_rt);
      exp_stall = hold || (lu && !flush);
      #1;
      total_cnt++; if (stall_id !== exp_stall) $display("FAIL rnd_stall_%0d: got %b want %b", n, stall_id, exp_stall); else pass_cnt++;

      if (!hold) begin
        if (flush || lu || !id_valid) begin
          m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.a = 32'h0; m.b = 32'h0; m.op = ALU_ADDU;
        end else begin
          fr = model_fwd(m, id_rs, id_rs_data);
          ft = model_fwd(m, id_rt, id_rt_data);
          m.a = id_asel ? ft : fr;
          case (id_bsel)
            2'd0:    m.b = ft;
            2'd1:    m.b = id_imm;
            2'd2:    m.b = 32'(id_shamt);
            default: m.b = 32'h0;
          endcase
          m.rtd = ft; m.valid = 1'b1; m.rw = id_reg_write; m.mr = id_mem_read;
          m.op = id_aluop; m.dest = id_dest;
        end
        if (lu && !flush && m.cnt < 65535) m.cnt++;
      end
      tick();
      total_cnt++; if ({ex_valid, ex_reg_write, ex_mem_read} !== {m.valid, m.rw, m.mr}) $display("FAIL rnd_ctrl_%0d: got %b want %b", n, {ex_valid, ex_reg_write, ex_mem_read}, {m.valid, m.rw, m.mr}); else pass_cnt++;
      total_cnt++; if (ex_a !== m.a) $display("FAIL rnd_a_%0d: got %h want %h", n, ex_a, m.a); else pass_cnt++;
      total_cnt++; if (ex_b !== m.b) $display("FAIL rnd_b_%0d: got %h want %h", n, ex_b, m.b); else pass_cnt++;
      total_cnt++; if (ex_aluop !== m.op || ex_dest !== m.dest) $display("FAIL rnd_op_dest_%0d: got %h/%h want %h/%h", n, ex_aluop, ex_dest, m.op, m.dest); else pass_cnt++;
      total_cnt++; if (ex_rt_data !== m.rtd) $display("FAIL rnd_rtdata_%0d: got %h want %h", n, ex_rt_data, m.rtd); else pass_cnt++;
      total_cnt++; if (stall_cnt !== 16'(m.cnt)) $display("FAIL rnd_cnt_%0d: got %0d want %0d", n, stall_cnt, m.cnt); else pass_cnt++;
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_reset_mid_stall();
    test_basic();
    test_forward_priority();
    test_load_use();
    test_shift();
    test_flush_load_use();
    test_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
